// File: rtl/alu_pkg.sv
// Purpose: shared types for the pipelined ALU (function codes, request/response words).
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package alu_pkg;

    localparam int ALU_W = 32;

    // Function encoding matches the combinational ALU so its vectors stay valid.
    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_ILL  = 3'b011,
        OP_ANDN = 3'b100,
        OP_ORN  = 3'b101,
        OP_SUB  = 3'b110,
        OP_SLT  = 3'b111
    } alu_op_e;

    typedef struct packed {
        alu_op_e            f;
        logic [ALU_W-1:0]   a;
        logic [ALU_W-1:0]   b;
    } alu_req_t;

    typedef struct packed {
        logic [ALU_W-1:0]   y;
        logic               zero;
        logic               of;
    } alu_rsp_t;

    // Signed overflow of an addition given the operand sign bits and the result sign.
    // Subtraction reuses this with the B sign inverted.
    function automatic logic add_ovf(input logic sign_a, input logic sign_b, input logic sign_r);
        return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purpose: combinational ALU datapath, one alu_req_t in, one alu_rsp_t out.
// Latency: 0 cycles (pure logic between the S1 and S2 registers).
// Backpressure: none; the enclosing pipeline decides when the result is captured.
module alu_core
    import alu_pkg::*;
(
    input  alu_req_t req_i,
    output alu_rsp_t rsp_o
);

    localparam int MSB = ALU_W - 1;

    logic [ALU_W-1:0] sum;
    logic [ALU_W-1:0] diff;
    logic             of_add;
    logic             of_sub;
    logic [ALU_W-1:0] y;
    logic             of;

    // Arithmetic, function select and flag generation; zero is taken from the final y.
    always_comb begin
        sum    = req_i.a + req_i.b;
        diff   = req_i.a - req_i.b;
        of_add = add_ovf(req_i.a[MSB], req_i.b[MSB], sum[MSB]);
        of_sub = add_ovf(req_i.a[MSB], ~req_i.b[MSB], diff[MSB]);
        y      = '0;
        of     = 1'b0;
        case (req_i.f)
            OP_AND:  y = req_i.a & req_i.b;
            OP_OR:   y = req_i.a | req_i.b;
            OP_ADD: begin
                y  = sum;
                of = of_add;
            end
            OP_ANDN: y = req_i.a & ~req_i.b;
            OP_ORN:  y = req_i.a | ~req_i.b;
            OP_SUB: begin
                y  = diff;
                of = of_sub;
            end
            // Correcting the difference sign with the overflow bit gives a true signed
            // compare even when A-B overflows.
            OP_SLT:  y = {{(ALU_W-1){1'b0}}, diff[MSB] ^ of_sub};
            // Illegal code yields all-zero with no flags raised besides zero.
            default: y = '0;
        endcase
        rsp_o.y    = y;
        rsp_o.zero = (y == '0);
        rsp_o.of   = of;
    end

endmodule

// File: rtl/alu_pipe.sv
// Purpose: two-stage pipelined ALU with valid/ready on both sides; optional
//          output handshake counter when ALU_PIPE_STATS_EN is defined.
// Latency: accept at edge N -> out_valid after edge N+1; 1 op/cycle when unstalled.
// Backpressure: stages advance into empty or draining slots; in_ready is combinational from out_ready.
module alu_pipe
    import alu_pkg::*;
#(
    // Operand/result width; must equal ALU_W, which sizes the shared request/response types.
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_f,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_of
`ifdef ALU_PIPE_STATS_EN
    ,
    output logic [31:0]      op_count
`endif
);

    // Stage 1: captured operation
    logic     s1_valid_q, s1_valid_d;
    alu_req_t s1_req_q,   s1_req_d;

    // Stage 2: registered result and flags, driven straight to the outputs
    logic     s2_valid_q, s2_valid_d;
    alu_rsp_t s2_rsp_q,   s2_rsp_d;

    alu_rsp_t core_rsp;
    logic     s1_adv;
    logic     s2_adv;
    logic     in_acc;

    alu_core u_core (
        .req_i (s1_req_q),
        .rsp_o (core_rsp)
    );

    // A stage may advance when it is empty or when its contents move on this cycle.
    assign s2_adv   = ~s2_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv;
    assign in_acc   = in_valid & s1_adv;

    assign out_valid = s2_valid_q;
    assign out_y     = s2_rsp_q.y;
    assign out_zero  = s2_rsp_q.zero;
    assign out_of    = s2_rsp_q.of;

    // Next-state for both stages; payload registers only load on a real transfer so
    // inputs are ignored while stalled and the output holds under backpressure.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_req_d   = s1_req_q;
        s2_valid_d = s2_valid_q;
        s2_rsp_d   = s2_rsp_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
        end
        if (in_acc) begin
            s1_req_d = '{f: alu_op_e'(in_f), a: in_a, b: in_b};
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_rsp_d = core_rsp;
            end
        end
    end

    // Pipeline state; reset discards anything in flight and clears the visible result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_req_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_rsp_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_req_q   <= s1_req_d;
            s2_valid_q <= s2_valid_d;
            s2_rsp_q   <= s2_rsp_d;
        end
    end

`ifdef ALU_PIPE_STATS_EN
    logic [31:0] op_count_q, op_count_d;

    // Completed results: one per output handshake, wrapping naturally at 2^32.
    always_comb begin
        op_count_d = op_count_q;
        if (s2_valid_q & out_ready) begin
            op_count_d = op_count_q + 32'd1;
        end
    end

    // Counter register, cleared together with the pipeline.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Two-stage pipelined 32-bit ALU with valid/ready handshakes on both sides. It sits behind the team's vector-driven ALU bench and any sequencer that issues {f, a, b} operations. It returns {y, zero, OF} in order, one result per accepted operation, with full backpressure support. Function encoding and flag semantics match the combinational ALU, so the same test vectors stay valid.

## Interface
- `WIDTH`, 32, operand/result width
- `clk` in 1, rising-edge clock
- `reset` in 1, synchronous, active-low
- `in_valid` in 1, operation offered
- `in_ready` out 1, operation accepted when `in_valid & in_ready`
- `in_f` in 3, function code
- `in_a` in WIDTH, operand A
- `in_b` in WIDTH, operand B
- `out_valid` out 1, result available
- `out_ready` in 1, result consumed when `out_valid & out_ready`
- `out_y` out WIDTH, result
- `out_zero` out 1, `out_y == 0`
- `out_of` out 1, signed overflow (add/sub only)
- `op_count` out 32, completed results; present only with `ALU_PIPE_STATS_EN`

## Operation
- Function codes: 000 AND; 001 OR; 010 ADD; 100 A AND ~B; 101 A OR ~B; 110 SUB (A-B); 111 SLT (signed). 011 is illegal.
- ADD/SUB use WIDTH-bit wraparound. The carry is discarded.
- `out_of` for ADD is `a[W-1]==b[W-1] && y[W-1]!=a[W-1]`.
- `out_of` for SUB is `a[W-1]!=b[W-1] && diff[W-1]!=a[W-1]`.
- `out_of` is 0 for all other codes.
- SLT: `y = {0.., diff[W-1] ^ of_sub}`. This is a true signed compare that is correct even when the subtraction overflows. `out_of` = 0.
- Illegal 011: y = 0, zero = 1, of = 0. No other side effect.
- `out_zero` is computed from the final y for every code.
- Stage 1 (S1): registers f, a, b and `s1_valid` on accept.
- Stage 2 (S2): computes from the S1 registers and registers y, zero, of and `s2_valid`.
- Advance rules:
  - `s2_adv = ~s2_valid | out_ready`
  - `s1_adv = ~s1_valid | s2_adv`
  - `in_ready = s1_adv`, a combinational path from `out_ready`
- Results are in order. No drop, no duplication.
- While `out_valid & ~out_ready`, `out_y`, `out_zero` and `out_of` hold stable.
- Inputs are sampled only on accept. Input changes while `in_ready` = 0 have no effect.

## Timing
- Reset (`reset` = 0 at an edge): `s1_valid`, `s2_valid`, `out_y`, `out_zero`, `out_of` and `op_count` all go to 0.
- After reset: `out_valid` = 0 and `in_ready` = 1.
- Reset mid-operation discards in-flight operations. Nothing is emitted afterwards.
- Latency: an operation accepted at edge N has `out_valid` = 1 after edge N+1, provided the pipeline does not stall. It can be consumed at edge N+2.
- Throughput: 1 op/cycle when `out_ready` stays high.
- Full pipeline: `s1_valid & s2_valid & ~out_ready` gives `in_ready` = 0.
- Simultaneous output consume and input accept with the pipeline full: both stages shift the same cycle and `in_ready` stays 1.
- The flags are registered with y and never lag or lead it.

## Configuration
- `ALU_PIPE_STATS_EN` defined:
  - `op_count` port exists.
  - It increments by 1 on each output handshake.
  - It wraps 0xFFFFFFFF to 0 and clears on reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- `alu_pkg` holds:
  - `alu_op_e` enum: OP_AND, OP_OR, OP_ADD, OP_ILL, OP_ANDN, OP_ORN, OP_SUB, OP_SLT
  - `ALU_W` = 32
  - a packed `alu_req_t` {f, a, b}
  - a packed `alu_rsp_t` {y, zero, of}
- Sub-module `alu_core`: purely combinational `alu_req_t` -> `alu_rsp_t`, instanced between S1 and S2.
- `alu_pipe` owns only handshake, registers and the optional counter.

## Test plan
- Reset held low 3 cycles with `in_valid` = 1 -> `out_valid` = 0 and no accept. After release, `in_ready` = 1 and `op_count` = 0.
- ADD 0x7FFFFFFF + 0x00000001 with `out_ready` = 1 -> two edges later y = 0x80000000, of = 1, zero = 0.
- SUB 0x00000005 - 0x00000005 -> y = 0, zero = 1, of = 0.
- Illegal f = 011 -> y = 0, zero = 1, of = 0.
- SLT cases, each of = 0:
  - 0x80000000 vs 0x00000001 -> y = 1
  - 0x7FFFFFFF vs 0x80000000 -> y = 0
  - 3 vs 3 -> y = 0
- Backpressure and reset:
  - `out_ready` = 0 while offering ANDs of a = 0xF0F0F0F0 with b = 1, 2, 3 -> two accepted, then `in_ready` = 0 and `out_y` holds 0x00000000.
  - Raise `out_ready` -> results appear in order, third accepted, none lost, `op_count` = 3 with stats enabled.
  - Assert `reset` mid-stream -> `out_valid` = 0 the next cycle and no stale result emitted.
